// File: rtl/ff_write_merger.sv
// Two-channel write merger: per-channel FIFOs drained round-robin onto one registered write strobe.
// Optional grant counters are enabled with `define FF_WRITE_MERGER_STATS_EN.
module ff_write_merger #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ch1_valid_i,
    input  logic [DATA_WIDTH-1:0]   ch1_data_i,
    output logic                    ch1_ready_o,
    input  logic                    ch2_valid_i,
    input  logic [DATA_WIDTH-1:0]   ch2_data_i,
    output logic                    ch2_ready_o,
    input  logic                    wr_stall_i,
    output logic                    wr_en_o,
    output logic [DATA_WIDTH-1:0]   wr_data_o,
    output logic                    wr_src_o,
`ifdef FF_WRITE_MERGER_STATS_EN
    output logic [CNT_WIDTH-1:0]    cnt1_o,
    output logic [CNT_WIDTH-1:0]    cnt2_o,
`endif
    output logic [$clog2(DEPTH):0]  occ1_o,
    output logic [$clog2(DEPTH):0]  occ2_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned OW = PW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CNT_WIDTH == 0) begin : gen_bad_param
        $error("ff_write_merger: DEPTH must be a power of 2 >= 2 and CNT_WIDTH > 0");
    end

    logic [1:0]                 ch_valid;
    logic [1:0]                 ch_ready;
    logic [1:0]                 push;
    logic [1:0]                 pop;
    logic [1:0]                 nonempty;
    logic [1:0][DATA_WIDTH-1:0] ch_data;
    logic [1:0][DATA_WIDTH-1:0] head;
    logic [1:0][OW-1:0]         occ;

    logic                  grant;
    logic                  sel;
    logic                  rr_q;
    logic                  wr_en_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic                  wr_src_q;

    assign ch_valid = {ch2_valid_i, ch1_valid_i};
    assign ch_data  = {ch2_data_i, ch1_data_i};

    for (genvar c = 0; c < 2; c++) begin : gen_fifo
        logic [DATA_WIDTH-1:0] mem_q [DEPTH];
        logic [PW-1:0]         wptr_q;
        logic [PW-1:0]         rptr_q;
        logic [OW-1:0]         occ_q;

        // Ready depends only on occupancy: a full FIFO refuses even when popped this cycle.
        assign ch_ready[c] = rst && (occ_q < OW'(DEPTH));
        assign push[c]     = ch_valid[c] && ch_ready[c];
        assign nonempty[c] = (occ_q != '0);
        assign head[c]     = mem_q[rptr_q];
        assign occ[c]      = occ_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                wptr_q <= '0;
                rptr_q <= '0;
                occ_q  <= '0;
            end else begin
                if (push[c]) wptr_q <= wptr_q + PW'(1);
                if (pop[c])  rptr_q <= rptr_q + PW'(1);
                occ_q <= occ_q + OW'(push[c]) - OW'(pop[c]);
            end
        end

        always_ff @(posedge clk) begin
            if (push[c]) mem_q[wptr_q] <= ch_data[c];
        end
    end

    // rr_q = 0 favours ch1, 1 favours ch2; it only matters when both FIFOs hold data.
    always_comb begin
        grant = 1'b0;
        sel   = 1'b0;
        if (!wr_stall_i) begin
            if (nonempty[0] && (!nonempty[1] || !rr_q)) begin
                grant = 1'b1;
                sel   = 1'b0;
            end else if (nonempty[1]) begin
                grant = 1'b1;
                sel   = 1'b1;
            end
        end
    end

    assign pop = {grant && sel, grant && !sel};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            wr_src_q  <= 1'b0;
            rr_q      <= 1'b0;
        end else begin
            wr_en_q <= grant;
            if (grant) begin
                wr_data_q <= head[sel];
                wr_src_q  <= sel;
                rr_q      <= !sel;
            end
        end
    end

`ifdef FF_WRITE_MERGER_STATS_EN
    logic [CNT_WIDTH-1:0] cnt1_q;
    logic [CNT_WIDTH-1:0] cnt2_q;

    // Saturating grant counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt1_q <= '0;
            cnt2_q <= '0;
        end else begin
            if (grant && !sel && (cnt1_q != '1)) cnt1_q <= cnt1_q + CNT_WIDTH'(1);
            if (grant && sel && (cnt2_q != '1))  cnt2_q <= cnt2_q + CNT_WIDTH'(1);
        end
    end

    assign cnt1_o = cnt1_q;
    assign cnt2_o = cnt2_q;
`endif

    assign ch1_ready_o = ch_ready[0];
    assign ch2_ready_o = ch_ready[1];
    assign wr_en_o     = wr_en_q;
    assign wr_data_o   = wr_data_q;
    assign wr_src_o    = wr_src_q;
    assign occ1_o      = occ[0];
    assign occ2_o      = occ[1];

endmodule

// File: tb/tb_ff_write_merger.sv
// Self-checking bench for ff_write_merger: queue-based reference model plus directed scenarios.
// Stats scenario runs only when FF_WRITE_MERGER_STATS_EN is defined.
module tb_ff_write_merger;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CW    = 2;
    localparam int unsigned OW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ch1_valid_i = 1'b0;
    logic [DW-1:0] ch1_data_i = '0;
    logic          ch1_ready_o;
    logic          ch2_valid_i = 1'b0;
    logic [DW-1:0] ch2_data_i = '0;
    logic          ch2_ready_o;
    logic          wr_stall_i = 1'b0;
    logic          wr_en_o;
    logic [DW-1:0] wr_data_o;
    logic          wr_src_o;
    logic [OW-1:0] occ1_o;
    logic [OW-1:0] occ2_o;
`ifdef FF_WRITE_MERGER_STATS_EN
    logic [CW-1:0] cnt1_o;
    logic [CW-1:0] cnt2_o;
`endif

    always #5 clk = ~clk;

    ff_write_merger #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ch1_valid_i (ch1_valid_i),
        .ch1_data_i  (ch1_data_i),
        .ch1_ready_o (ch1_ready_o),
        .ch2_valid_i (ch2_valid_i),
        .ch2_data_i  (ch2_data_i),
        .ch2_ready_o (ch2_ready_o),
        .wr_stall_i  (wr_stall_i),
        .wr_en_o     (wr_en_o),
        .wr_data_o   (wr_data_o),
        .wr_src_o    (wr_src_o),
`ifdef FF_WRITE_MERGER_STATS_EN
        .cnt1_o      (cnt1_o),
        .cnt2_o      (cnt2_o),
`endif
        .occ1_o      (occ1_o),
        .occ2_o      (occ2_o)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one queue per channel, strict round-robin when both hold data.
    logic [DW-1:0] q1[$];
    logic [DW-1:0] q2[$];
    logic          m_en   = 1'b0;
    logic [DW-1:0] m_data = '0;
    logic          m_src  = 1'b0;
    logic          m_rr   = 1'b0;
    logic          m_p1   = 1'b0;
    logic          m_p2   = 1'b0;
    int            m_cnt1 = 0;
    int            m_cnt2 = 0;
    int            m_cmax = (1 << CW) - 1;

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                q1.delete();
                q2.delete();
                m_en   = 1'b0;
                m_data = '0;
                m_src  = 1'b0;
                m_rr   = 1'b0;
                m_cnt1 = 0;
                m_cnt2 = 0;
            end else begin
                m_p1 = ch1_valid_i && (q1.size() < DEPTH);
                m_p2 = ch2_valid_i && (q2.size() < DEPTH);
                m_en = 1'b0;
                if (!wr_stall_i && (q1.size() > 0 || q2.size() > 0)) begin
                    m_src = (q1.size() > 0 && (q2.size() == 0 || !m_rr)) ? 1'b0 : 1'b1;
                    m_en  = 1'b1;
                    if (!m_src) begin
                        m_data = q1.pop_front();
                        if (m_cnt1 < m_cmax) m_cnt1++;
                    end else begin
                        m_data = q2.pop_front();
                        if (m_cnt2 < m_cmax) m_cnt2++;
                    end
                    m_rr = !m_src;
                end
                if (m_p1) q1.push_back(ch1_data_i);
                if (m_p2) q2.push_back(ch2_data_i);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                check("m_wr_en", 64'(wr_en_o), 64'(m_en));
                check("m_wr_data", 64'(wr_data_o), 64'(m_data));
                check("m_wr_src", 64'(wr_src_o), 64'(m_src));
                check("m_occ1", 64'(occ1_o), 64'(q1.size()));
                check("m_occ2", 64'(occ2_o), 64'(q2.size()));
                check("m_ready1", 64'(ch1_ready_o), 64'(q1.size() < DEPTH));
                check("m_ready2", 64'(ch2_ready_o), 64'(q2.size() < DEPTH));
`ifdef FF_WRITE_MERGER_STATS_EN
                check("m_cnt1", 64'(cnt1_o), 64'(m_cnt1));
                check("m_cnt2", 64'(cnt2_o), 64'(m_cnt2));
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        ch1_valid_i = 1'b0;
        ch2_valid_i = 1'b0;
        wr_stall_i  = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    logic [DW-1:0] d1, d2, e1, e2;
    logic          r1, r2, prev_src, have_prev;
    logic [DW-1:0] stall_exp [4];
    int            n1, n2;

    initial begin
        // Reset state
        step();
        step();
        check("rst_ready1", 64'(ch1_ready_o), 64'(0));
        check("rst_ready2", 64'(ch2_ready_o), 64'(0));
        check("rst_wr_en", 64'(wr_en_o), 64'(0));
        check("rst_occ1", 64'(occ1_o), 64'(0));
        rst = 1'b1;

        // Single write: two-cycle latency, single pulse
        ch1_valid_i = 1'b1;
        ch1_data_i  = 32'hAAAA_0001;
        step();
        ch1_valid_i = 1'b0;
        check("single_occ1", 64'(occ1_o), 64'(1));
        check("single_en_early", 64'(wr_en_o), 64'(0));
        step();
        check("single_en", 64'(wr_en_o), 64'(1));
        check("single_data", 64'(wr_data_o), 64'(32'hAAAA_0001));
        check("single_src", 64'(wr_src_o), 64'(0));
        step();
        check("single_en_after", 64'(wr_en_o), 64'(0));
        check("single_hold", 64'(wr_data_o), 64'(32'hAAAA_0001));

        // Simultaneous writes: both survive, ch1 first
        do_reset();
        ch1_valid_i = 1'b1;
        ch1_data_i  = 32'h11;
        ch2_valid_i = 1'b1;
        ch2_data_i  = 32'h22;
        step();
        ch1_valid_i = 1'b0;
        ch2_valid_i = 1'b0;
        step();
        check("simul_en0", 64'(wr_en_o), 64'(1));
        check("simul_data0", 64'(wr_data_o), 64'(32'h11));
        check("simul_src0", 64'(wr_src_o), 64'(0));
        step();
        check("simul_en1", 64'(wr_en_o), 64'(1));
        check("simul_data1", 64'(wr_data_o), 64'(32'h22));
        check("simul_src1", 64'(wr_src_o), 64'(1));
        step();
        check("simul_en_after", 64'(wr_en_o), 64'(0));

        // Fairness under continuous dual traffic
        d1 = 32'h1000;
        d2 = 32'h2000;
        e1 = 32'h1000;
        e2 = 32'h2000;
        have_prev = 1'b0;
        prev_src  = 1'b0;
        for (int i = 0; i < 18; i++) begin
            ch1_valid_i = 1'b1;
            ch1_data_i  = d1;
            ch2_valid_i = 1'b1;
            ch2_data_i  = d2;
            r1 = ch1_ready_o;
            r2 = ch2_ready_o;
            step();
            if (r1) d1++;
            if (r2) d2++;
            if (wr_en_o) begin
                check("fair_order", 64'(wr_data_o), 64'(wr_src_o ? e2 : e1));
                if (wr_src_o) e2++;
                else e1++;
                if (have_prev) check("fair_alternate", 64'(wr_src_o), 64'(!prev_src));
                prev_src  = wr_src_o;
                have_prev = 1'b1;
            end
        end
        ch1_valid_i = 1'b0;
        ch2_valid_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (wr_en_o) begin
                check("drain_order", 64'(wr_data_o), 64'(wr_src_o ? e2 : e1));
                if (wr_src_o) e2++;
                else e1++;
            end
        end
        check("fair_all_ch1", 64'(e1), 64'(d1));
        check("fair_all_ch2", 64'(e2), 64'(d2));

        // Stall with both FIFOs full
        do_reset();
        wr_stall_i  = 1'b1;
        ch1_valid_i = 1'b1;
        ch1_data_i  = 32'h31;
        ch2_valid_i = 1'b1;
        ch2_data_i  = 32'h41;
        step();
        ch1_data_i = 32'h32;
        ch2_data_i = 32'h42;
        step();
        ch1_valid_i = 1'b0;
        ch2_valid_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_en", 64'(wr_en_o), 64'(0));
            check("stall_occ1", 64'(occ1_o), 64'(2));
            check("stall_occ2", 64'(occ2_o), 64'(2));
            check("stall_ready1", 64'(ch1_ready_o), 64'(0));
            check("stall_ready2", 64'(ch2_ready_o), 64'(0));
        end
        wr_stall_i = 1'b0;
        stall_exp = '{32'h31, 32'h41, 32'h32, 32'h42};
        for (int k = 0; k < 4; k++) begin
            step();
            check("unstall_en", 64'(wr_en_o), 64'(1));
            check("unstall_data", 64'(wr_data_o), 64'(stall_exp[k]));
            check("unstall_src", 64'(wr_src_o), 64'(k % 2));
        end
        step();
        check("unstall_en_after", 64'(wr_en_o), 64'(0));

        // Asynchronous reset mid-operation
        do_reset();
        ch1_valid_i = 1'b1;
        ch1_data_i  = 32'h51;
        step();
        ch1_data_i = 32'h52;
        step();
        ch1_valid_i = 1'b0;
        check("mid_pre_en", 64'(wr_en_o), 64'(1));
        check("mid_pre_occ1", 64'(occ1_o), 64'(1));
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_en", 64'(wr_en_o), 64'(0));
        check("mid_rst_data", 64'(wr_data_o), 64'(0));
        check("mid_rst_occ1", 64'(occ1_o), 64'(0));
        check("mid_rst_occ2", 64'(occ2_o), 64'(0));
        check("mid_rst_ready1", 64'(ch1_ready_o), 64'(0));
        step();
        rst = 1'b1;
        ch1_valid_i = 1'b1;
        ch1_data_i  = 32'h61;
        ch2_valid_i = 1'b1;
        ch2_data_i  = 32'h62;
        step();
        ch1_valid_i = 1'b0;
        ch2_valid_i = 1'b0;
        step();
        check("post_rst_data0", 64'(wr_data_o), 64'(32'h61));
        check("post_rst_src0", 64'(wr_src_o), 64'(0));
        step();
        check("post_rst_data1", 64'(wr_data_o), 64'(32'h62));
        check("post_rst_src1", 64'(wr_src_o), 64'(1));

`ifdef FF_WRITE_MERGER_STATS_EN
        // Saturating counters: 5 ch1 grants, 1 ch2 grant
        do_reset();
        n1 = 0;
        n2 = 0;
        for (int i = 0; i < 10; i++) begin
            ch1_valid_i = (n1 < 5);
            ch1_data_i  = 32'h70 + n1;
            ch2_valid_i = (n2 < 1);
            ch2_data_i  = 32'h80;
            r1 = ch1_valid_i && ch1_ready_o;
            r2 = ch2_valid_i && ch2_ready_o;
            step();
            if (r1) n1++;
            if (r2) n2++;
        end
        ch1_valid_i = 1'b0;
        ch2_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("stats_cnt1_sat", 64'(cnt1_o), 64'(3));
        check("stats_cnt2", 64'(cnt2_o), 64'(1));
`endif

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
